// File: rtl/risc_v_regfile_mp.sv
// ---------------------------------------------------------------------------
// risc_v_regfile_mp
// Multi-read-port integer register file for the RISC-V ID stage.
//  - One clocked write port; NRD independent combinational read ports.
//  - Optional write-through bypass (WB->ID in the same cycle).
//  - After reset a clear sweep zeroes one entry per cycle; busy is high
//    while the sweep runs. During the sweep writes are ignored and every
//    read port returns zero.
//  - x0 always reads zero. Writes to x0 or to an address >= NREGS are dropped.
// Ports:
//  clk     rising-edge clock
//  reset   synchronous, active-high reset (restarts the clear sweep)
//  r_addr  NRD packed read addresses, port k = r_addr[k*AW +: AW]
//  r_data  NRD packed read data,      port k = r_data[k*XLEN +: XLEN]
//  w_en    write enable
//  w_addr  write address
//  w_data  write data
//  busy    clear sweep in progress
// ---------------------------------------------------------------------------
module risc_v_regfile_mp #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int NRD    = 2,
    parameter int BYPASS = 1,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NRD*AW-1:0]     r_addr,
    output logic [NRD*XLEN-1:0]   r_data,
    input  logic                  w_en,
    input  logic [AW-1:0]         w_addr,
    input  logic [XLEN-1:0]       w_data,
    output logic                  busy
);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    localparam logic [AW-1:0] CLR_LAST = AW'(NREGS - 1);
    localparam logic [AW-1:0] CNT_ONE  = AW'(1);
    // One extra bit so the range compare also works when NREGS is a power of two.
    localparam logic [AW:0]   NREGS_X  = (AW + 1)'(NREGS);

    // Address names a writable/readable register (not x0, not past the end).
    function automatic logic addr_valid(input logic [AW-1:0] a);
        addr_valid = (a != {AW{1'b0}}) && ({1'b0, a} < NREGS_X);
    endfunction

    state_t             state_r;
    state_t             state_nxt_s;
    logic [AW-1:0]      clr_cnt_r;
    logic [AW-1:0]      clr_cnt_nxt_s;
    logic               busy_r;
    logic               write_ok_s;
    logic [XLEN-1:0]    regs_r [NREGS];

    // Next-state logic of the clear sequencer.
    always_comb begin
        state_nxt_s   = state_r;
        clr_cnt_nxt_s = clr_cnt_r;
        case (state_r)
            ST_CLEAR: begin
                if (clr_cnt_r == CLR_LAST) begin
                    // Last entry is cleared on this edge; counter parks, never wraps.
                    state_nxt_s   = ST_RUN;
                    clr_cnt_nxt_s = clr_cnt_r;
                end else begin
                    state_nxt_s   = ST_CLEAR;
                    clr_cnt_nxt_s = clr_cnt_r + CNT_ONE;
                end
            end
            ST_RUN: begin
                state_nxt_s   = ST_RUN;
                clr_cnt_nxt_s = clr_cnt_r;
            end
            default: begin
                state_nxt_s   = ST_CLEAR;
                clr_cnt_nxt_s = {AW{1'b0}};
            end
        endcase
    end

    // Sequencer state, clear counter and registered busy flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= ST_CLEAR;
            clr_cnt_r <= {AW{1'b0}};
            busy_r    <= 1'b1;
        end else begin
            state_r   <= state_nxt_s;
            clr_cnt_r <= clr_cnt_nxt_s;
            busy_r    <= (state_nxt_s == ST_CLEAR);
        end
    end

    assign busy = busy_r;

    // Qualified write: only in RUN, never on a reset edge, never to x0 / out of range.
    always_comb begin
        write_ok_s = 1'b0;
        if (!reset && (state_r == ST_RUN) && w_en && addr_valid(w_addr)) begin
            write_ok_s = 1'b1;
        end else begin
            write_ok_s = 1'b0;
        end
    end

    // Register array: clear sweep has priority, otherwise the qualified write.
    always_ff @(posedge clk) begin
        if (!reset && (state_r == ST_CLEAR)) begin
            regs_r[clr_cnt_r] <= {XLEN{1'b0}};
        end else if (write_ok_s) begin
            regs_r[w_addr] <= w_data;
        end
    end

    // Combinational read ports with optional same-cycle write-through.
    always_comb begin
        r_data = {(NRD*XLEN){1'b0}};
        for (int k = 0; k < NRD; k++) begin
            if (state_r == ST_CLEAR) begin
                r_data[k*XLEN +: XLEN] = {XLEN{1'b0}};
            end else if (!addr_valid(r_addr[k*AW +: AW])) begin
                r_data[k*XLEN +: XLEN] = {XLEN{1'b0}};
            end else if ((BYPASS != 0) && write_ok_s && (w_addr == r_addr[k*AW +: AW])) begin
                r_data[k*XLEN +: XLEN] = w_data;
            end else begin
                r_data[k*XLEN +: XLEN] = regs_r[r_addr[k*AW +: AW]];
            end
        end
    end

endmodule

// File: tb/tb_risc_v_regfile_mp.sv
// Bench for risc_v_regfile_mp: three instances share clk/reset.
//  a: XLEN=32 NREGS=32 NRD=2 BYPASS=1
//  b: same as a, BYPASS=0, driven by the same inputs
//  c: XLEN=64 NREGS=24 NRD=4 BYPASS=1, own write/read inputs
// The reference model treats a reset as "all registers zero, busy for NREGS
// further cycles"; writes are ignored while busy.
module tb_risc_v_regfile_mp;

    logic         clk;
    logic         reset;

    logic [9:0]   ra_a;
    logic [63:0]  rd_a;
    logic [63:0]  rd_b;
    logic         w_en;
    logic [4:0]   w_addr;
    logic [31:0]  w_data;
    logic         busy_a;
    logic         busy_b;

    logic [19:0]  ra_c;
    logic [255:0] rd_c;
    logic         c_w_en;
    logic [4:0]   c_w_addr;
    logic [63:0]  c_w_data;
    logic         busy_c;

    int total = 0;
    int bad   = 0;

    logic [31:0]  m_a [32];
    logic [63:0]  m_c [24];
    int           pend_a;
    int           pend_c;
    logic         busy_seen;

    risc_v_regfile_mp #(.XLEN(32), .NREGS(32), .NRD(2), .BYPASS(1)) dut_a (
        .clk(clk), .reset(reset), .r_addr(ra_a), .r_data(rd_a),
        .w_en(w_en), .w_addr(w_addr), .w_data(w_data), .busy(busy_a)
    );

    risc_v_regfile_mp #(.XLEN(32), .NREGS(32), .NRD(2), .BYPASS(0)) dut_b (
        .clk(clk), .reset(reset), .r_addr(ra_a), .r_data(rd_b),
        .w_en(w_en), .w_addr(w_addr), .w_data(w_data), .busy(busy_b)
    );

    risc_v_regfile_mp #(.XLEN(64), .NREGS(24), .NRD(4), .BYPASS(1)) dut_c (
        .clk(clk), .reset(reset), .r_addr(ra_c), .r_data(rd_c),
        .w_en(c_w_en), .w_addr(c_w_addr), .w_data(c_w_data), .busy(busy_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_a(input logic [4:0] ra, input bit byp);
        if (pend_a > 0) return 32'h0;
        if (ra == 5'd0) return 32'h0;
        if (byp && !reset && w_en && (w_addr == ra)) return w_data;
        return m_a[ra];
    endfunction

    function automatic logic [63:0] exp_c(input logic [4:0] ra);
        if (pend_c > 0) return 64'h0;
        if (ra == 5'd0 || ra >= 5'd24) return 64'h0;
        if (!reset && c_w_en && (c_w_addr == ra)) return c_w_data;
        return m_c[ra];
    endfunction

    // Apply one clock edge of the reference model using the current inputs.
    task automatic model_edge();
        if (reset) begin
            for (int i = 0; i < 32; i++) m_a[i] = 32'h0;
            for (int i = 0; i < 24; i++) m_c[i] = 64'h0;
            pend_a = 32;
            pend_c = 24;
        end else begin
            if (pend_a > 0) pend_a--;
            else if (w_en && w_addr != 5'd0) m_a[w_addr] = w_data;
            if (pend_c > 0) pend_c--;
            else if (c_w_en && c_w_addr != 5'd0 && c_w_addr < 5'd24) m_c[c_w_addr] = c_w_data;
        end
    endtask

    // Check every output on the falling edge, then advance one rising edge.
    task automatic tick();
        @(negedge clk);
        chk("busy_a", 64'(busy_a), 64'(pend_a > 0));
        chk("busy_b", 64'(busy_b), 64'(pend_a > 0));
        chk("busy_c", 64'(busy_c), 64'(pend_c > 0));
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("rd_a%0d", k), 64'(rd_a[k*32 +: 32]), 64'(exp_a(ra_a[k*5 +: 5], 1'b1)));
            chk($sformatf("rd_b%0d", k), 64'(rd_b[k*32 +: 32]), 64'(exp_a(ra_a[k*5 +: 5], 1'b0)));
        end
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("rd_c%0d", k), rd_c[k*64 +: 64], exp_c(ra_c[k*5 +: 5]));
        end
        busy_seen = busy_a;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    initial begin
        int cnt;
        reset    = 1'b1;
        ra_a     = 10'd0;
        w_en     = 1'b0;
        w_addr   = 5'd0;
        w_data   = 32'h0;
        ra_c     = 20'd0;
        c_w_en   = 1'b0;
        c_w_addr = 5'd0;
        c_w_data = 64'h0;
        pend_a   = 32;
        pend_c   = 24;

        // T1: reset held three edges, then count busy cycles.
        @(posedge clk);
        model_edge();
        #1;
        tick();
        tick();
        reset = 1'b0;
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            ra_a = {5'(i), 5'(31 - i)};
            tick();
            if (busy_seen) cnt++;
        end
        chk("t1_busy_len", 64'(cnt), 64'd32);
        for (int i = 0; i < 32; i += 2) begin
            ra_a = {5'(i + 1), 5'(i)};
            ra_c = {5'(i), 5'(i + 1), 5'(31 - i), 5'(i / 2)};
            tick();
        end

        // T2: write x5, read it on the next cycle.
        w_en = 1'b1; w_addr = 5'd5; w_data = 32'hDEADBEEF; ra_a = 10'd0;
        tick();
        w_en = 1'b0; ra_a = {5'd0, 5'd5};
        #1;
        chk("t2_read_x5", 64'(rd_a[31:0]), 64'h00000000DEADBEEF);
        tick();

        // T3: same-cycle bypass on both ports; no bypass in instance b.
        w_en = 1'b1; w_addr = 5'd7; w_data = 32'h12345678; ra_a = {5'd7, 5'd7};
        #1;
        chk("t3_byp_p0", 64'(rd_a[31:0]),  64'h12345678);
        chk("t3_byp_p1", 64'(rd_a[63:32]), 64'h12345678);
        chk("t3_nobyp_p0", 64'(rd_b[31:0]),  64'h0);
        chk("t3_nobyp_p1", 64'(rd_b[63:32]), 64'h0);
        tick();
        w_en = 1'b0;
        #1;
        chk("t3_after_b", 64'(rd_b[31:0]), 64'h12345678);
        tick();

        // T4: writes to x0 never land and never bypass.
        w_en = 1'b1; w_addr = 5'd0; w_data = 32'hFFFFFFFF; ra_a = {5'd0, 5'd0};
        #1;
        chk("t4_x0_same", 64'(rd_a[31:0]), 64'h0);
        tick();
        w_en = 1'b0;
        #1;
        chk("t4_x0_next", 64'(rd_a[31:0]), 64'h0);
        tick();

        // T5: write x3, reset, pulse reset mid-sweep, write during busy is dropped.
        w_en = 1'b1; w_addr = 5'd3; w_data = 32'hA5A5A5A5; ra_a = {5'd3, 5'd3};
        tick();
        w_en = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            w_en   = (i < 20);
            w_addr = 5'd3;
            w_data = $urandom;
            tick();
            if (busy_seen) cnt++;
        end
        chk("t5_busy_len", 64'(cnt), 64'd32);
        w_en = 1'b0;
        #1;
        chk("t5_x3_cleared", 64'(rd_a[31:0]), 64'h0);
        tick();

        // T6: wide/narrow instance, last register and out-of-range write.
        c_w_en = 1'b1; c_w_addr = 5'd23; c_w_data = 64'h0123456789ABCDEF;
        tick();
        c_w_addr = 5'd30; c_w_data = 64'hFFFF0000FFFF0000;
        tick();
        c_w_en = 1'b0;
        ra_c = {5'd23, 5'd23, 5'd23, 5'd23};
        #1;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("t6_x23_p%0d", k), rd_c[k*64 +: 64], 64'h0123456789ABCDEF);
        end
        tick();
        ra_c = {5'd23, 5'd30, 5'd0, 5'd30};
        #1;
        chk("t6_addr30", rd_c[63:0], 64'h0);
        tick();

        // Randomised traffic against the model, biased toward read/write collisions.
        for (int i = 0; i < 300; i++) begin
            w_en     = ($urandom_range(0, 3) != 0);
            w_addr   = 5'($urandom_range(0, 31));
            w_data   = $urandom;
            ra_a[4:0] = ($urandom_range(0, 2) == 0) ? w_addr : 5'($urandom_range(0, 31));
            ra_a[9:5] = 5'($urandom_range(0, 31));
            c_w_en   = ($urandom_range(0, 3) != 0);
            c_w_addr = 5'($urandom_range(0, 31));
            c_w_data = {$urandom, $urandom};
            for (int k = 0; k < 4; k++) begin
                ra_c[k*5 +: 5] = ($urandom_range(0, 2) == 0) ? c_w_addr : 5'($urandom_range(0, 31));
            end
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
